wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between the pipeline writeback stage and a multi-cycle long-latency unit (mul/div).
- Buffers long-latency results in a small FIFO and drains them into free writeback slots.
- Keeps a scoreboard of registers awaiting a long-latency result, and gives the hazard unit a stall signal for RAW and WAW conflicts.
- Sits between writeback and the register file, and feeds the decode-stage hazard logic.

---
 rtl/wb_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the pipeline writeback
// stage and a long-latency unit (mul/div). Long-latency results that cannot
// be written straight away wait in a small FIFO and drain into free writeback
// slots. A one-bit-per-register scoreboard tracks registers still waiting for
// a long-latency result and drives the decode-stage stall (RAW and WAW).
//
// Ports:
//   clk, rstn                       clock (rising edge), synchronous active-low reset
//   wb_en, wb_reg, wb_data          pipeline writeback request
//   lu_valid, lu_reg, lu_data       long-latency result offer
//   lu_ready                        result accepted this cycle (with lu_valid)
//   issue_en, issue_reg             long-latency op issued; marks issue_reg pending
//   chk_rs1, chk_rs2, chk_rd        decode-stage operands to test against the scoreboard
//   hazard                          decode instruction must stall
//   write_en, write_reg, write_data register-file write port (combinational)
//   sb_error                        sticky: result arrived for a non-pending register
module wb_port_arbiter #(
  parameter int REG_WIDTH  = 32,
  parameter int REG_COUNT  = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int REG_BITS   = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 wb_en,
  input  logic [REG_BITS-1:0]  wb_reg,
  input  logic [REG_WIDTH-1:0] wb_data,
  input  logic                 lu_valid,
  input  logic [REG_BITS-1:0]  lu_reg,
  input  logic [REG_WIDTH-1:0] lu_data,
  output logic                 lu_ready,
  input  logic                 issue_en,
  input  logic [REG_BITS-1:0]  issue_reg,
  input  logic [REG_BITS-1:0]  chk_rs1,
  input  logic [REG_BITS-1:0]  chk_rs2,
  input  logic [REG_BITS-1:0]  chk_rd,
  output logic                 hazard,
  output logic                 write_en,
  output logic [REG_BITS-1:0]  write_reg,
  output logic [REG_WIDTH-1:0] write_data,
  output logic                 sb_error
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam logic [PTR_BITS:0]   CNT_FULL = (PTR_BITS + 1)'(FIFO_DEPTH);
  localparam logic [PTR_BITS:0]   CNT_ONE  = (PTR_BITS + 1)'(1);
  localparam logic [PTR_BITS-1:0] PTR_ONE  = PTR_BITS'(1);
  localparam logic [REG_BITS-1:0] REG_ZERO = {REG_BITS{1'b0}};

  logic [REG_BITS-1:0]  mem_reg_q  [FIFO_DEPTH];
  logic [REG_BITS-1:0]  mem_reg_d  [FIFO_DEPTH];
  logic [REG_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
  logic [REG_WIDTH-1:0] mem_data_d [FIFO_DEPTH];
  logic [PTR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS:0]    count_q, count_d;
  logic [REG_COUNT-1:0] pending_q, pending_d;
  logic                 sb_error_q, sb_error_d;

  logic slot_busy_s;
  logic fifo_empty_s;
  logic fifo_full_s;
  logic bypass_s;
  logic accept_s;
  logic push_s;
  logic pop_s;

  // Write-port arbitration: pipeline first, then FIFO head, then bypass.
  always_comb begin
    slot_busy_s  = wb_en && (wb_reg != REG_ZERO);
    fifo_empty_s = (count_q == {(PTR_BITS + 1){1'b0}});
    fifo_full_s  = (count_q == CNT_FULL);
    bypass_s     = rstn && !slot_busy_s && fifo_empty_s && lu_valid;
    lu_ready     = rstn && (!fifo_full_s || bypass_s);
    accept_s     = lu_valid && lu_ready;
    // Bypassed results and results to x0 never enter the FIFO.
    push_s       = accept_s && !bypass_s && (lu_reg != REG_ZERO);
    pop_s        = 1'b0;
    write_en     = 1'b0;
    write_reg    = REG_ZERO;
    write_data   = {REG_WIDTH{1'b0}};
    if (!rstn) begin
      write_en = 1'b0;
    end else if (slot_busy_s) begin
      write_en   = 1'b1;
      write_reg  = wb_reg;
      write_data = wb_data;
    end else if (!fifo_empty_s) begin
      pop_s      = 1'b1;
      write_en   = 1'b1;
      write_reg  = mem_reg_q[rd_ptr_q];
      write_data = mem_data_q[rd_ptr_q];
    end else if (bypass_s && (lu_reg != REG_ZERO)) begin
      write_en   = 1'b1;
      write_reg  = lu_reg;
      write_data = lu_data;
    end else begin
      write_en = 1'b0;
    end
  end

  // FIFO next state: pop and push may share a cycle (push only when not full).
  always_comb begin
    mem_reg_d  = mem_reg_q;
    mem_data_d = mem_data_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s) begin
      mem_reg_d[wr_ptr_q]  = lu_reg;
      mem_data_d[wr_ptr_q] = lu_data;
      wr_ptr_d             = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Scoreboard next state: clears on the actual write, then issue sets (set wins).
  always_comb begin
    pending_d  = pending_q;
    sb_error_d = sb_error_q;
    if (accept_s && (lu_reg != REG_ZERO) && !pending_q[lu_reg]) begin
      sb_error_d = 1'b1;
    end else begin
      sb_error_d = sb_error_q;
    end
    if (pop_s) begin
      pending_d[mem_reg_q[rd_ptr_q]] = 1'b0;
    end else if (bypass_s && (lu_reg != REG_ZERO)) begin
      pending_d[lu_reg] = 1'b0;
    end else begin
      pending_d = pending_d;
    end
    if (issue_en && (issue_reg != REG_ZERO)) begin
      pending_d[issue_reg] = 1'b1;
    end else begin
      pending_d = pending_d;
    end
    pending_d[0] = 1'b0;
  end

  // Stall from registered scoreboard only; x0 is masked on every operand.
  always_comb begin
    hazard = rstn && (((chk_rs1 != REG_ZERO) && pending_q[chk_rs1]) ||
                      ((chk_rs2 != REG_ZERO) && pending_q[chk_rs2]) ||
                      ((chk_rd  != REG_ZERO) && pending_q[chk_rd]));
    sb_error = sb_error_q;
  end

  // Control and scoreboard state; reset discards buffered results and pending bits.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr_q   <= {PTR_BITS{1'b0}};
      wr_ptr_q   <= {PTR_BITS{1'b0}};
      count_q    <= {(PTR_BITS + 1){1'b0}};
      pending_q  <= {REG_COUNT{1'b0}};
      sb_error_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      sb_error_q <= sb_error_d;
    end
  end

  // FIFO storage; contents are only meaningful under the count, so no reset.
  always_ff @(posedge clk) begin
    mem_reg_q  <= mem_reg_d;
    mem_data_q <= mem_data_d;
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int DEPTH = 2;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic [4:0]  lu_reg;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        issue_en;
  logic [4:0]  issue_reg;
  logic [4:0]  chk_rs1, chk_rs2, chk_rd;
  logic        hazard;
  logic        write_en;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        sb_error;

  int checks = 0;
  int errors = 0;

  // reference model: buffered results, pending flags, sticky error
  wr_t  mq[$];
  wr_t  exp_q[$];
  bit   pend[32];
  bit   sb_m;
  bit   last_acc;
  logic [4:0] outq[$];

  wb_port_arbiter #(.REG_WIDTH(32), .REG_COUNT(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_reg(lu_reg), .lu_data(lu_data), .lu_ready(lu_ready),
    .issue_en(issue_en), .issue_reg(issue_reg),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .hazard(hazard),
    .write_en(write_en), .write_reg(write_reg), .write_data(write_data),
    .sb_error(sb_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every register-file write must match the next expected write
  always @(negedge clk) begin
    if (write_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_reg", 32'(write_reg), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_reg", 32'(write_reg), 32'(e.r));
        chk("write_data", write_data, e.d);
      end
    end
  end

  function automatic bit pend_of(input logic [4:0] r);
    return (r != 5'd0) && pend[r];
  endfunction

  // One clock cycle with the current inputs: predict, check, advance model.
  task automatic step();
    bit busy, byp, rdy, acc, pop, hz;
    wr_t e;
    #1;
    busy = 1'b0; byp = 1'b0; rdy = 1'b0; acc = 1'b0; pop = 1'b0; hz = 1'b0;
    if (rstn) begin
      busy = wb_en && (wb_reg != 5'd0);
      hz   = pend_of(chk_rs1) || pend_of(chk_rs2) || pend_of(chk_rd);
      byp  = !busy && (mq.size() == 0) && lu_valid;
      rdy  = (mq.size() < DEPTH) || byp;
      acc  = lu_valid && rdy;
      pop  = !busy && (mq.size() != 0);
      if (busy) begin
        e.r = wb_reg; e.d = wb_data; exp_q.push_back(e);
      end else if (pop) begin
        exp_q.push_back(mq[0]);
      end else if (byp && lu_reg != 5'd0) begin
        e.r = lu_reg; e.d = lu_data; exp_q.push_back(e);
      end
    end
    chk("lu_ready", 32'(lu_ready), 32'(rdy));
    chk("hazard", 32'(hazard), 32'(hz));
    chk("sb_error", 32'(sb_error), 32'(sb_m));
    @(posedge clk);
    if (!rstn) begin
      mq.delete();
      foreach (pend[i]) pend[i] = 1'b0;
      sb_m = 1'b0;
    end else begin
      if (acc && lu_reg != 5'd0 && !pend[lu_reg]) sb_m = 1'b1;
      if (pop) begin
        e = mq.pop_front();
        pend[e.r] = 1'b0;
      end
      if (byp && lu_reg != 5'd0) pend[lu_reg] = 1'b0;
      if (acc && !byp && lu_reg != 5'd0) begin
        e.r = lu_reg; e.d = lu_data; mq.push_back(e);
      end
      if (issue_en && issue_reg != 5'd0) pend[issue_reg] = 1'b1;
    end
    last_acc = acc;
    #2;
    chk("missing_write", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic issue(input logic [4:0] r);
    issue_en = 1'b1; issue_reg = r;
    step();
    issue_en = 1'b0;
  endtask

  // Offer a result and hold it stable until accepted (bounded).
  task automatic send(input logic [4:0] r, input logic [31:0] d);
    lu_valid = 1'b1; lu_reg = r; lu_data = d;
    for (int k = 0; k < 12; k++) begin
      step();
      if (last_acc) break;
    end
    chk("send_accepted", 32'(last_acc), 32'd1);
    lu_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; wb_en = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
    lu_valid = 1'b0; lu_reg = 5'd0; lu_data = 32'd0;
    issue_en = 1'b0; issue_reg = 5'd0;
    chk_rs1 = 5'd0; chk_rs2 = 5'd0; chk_rd = 5'd0;
    sb_m = 1'b0; last_acc = 1'b0;
    foreach (pend[i]) pend[i] = 1'b0;
    step(); step();
    rstn = 1'b1;
    step();

    // bypass into an idle port
    issue(5'd5);
    chk_rs1 = 5'd5;
    send(5'd5, 32'h1234);
    step();
    chk_rs1 = 5'd0;

    // conflict with pipeline: enqueue then drain
    issue(5'd6);
    wb_en = 1'b1; wb_reg = 5'd3; wb_data = 32'd7;
    send(5'd6, 32'd9);
    wb_en = 1'b0;
    step();

    // fill the FIFO while the pipeline holds the port
    issue(5'd1); issue(5'd2); issue(5'd4);
    begin
      int hold;
      hold = 0;
      wb_en = 1'b1; wb_reg = 5'd3; wb_data = 32'h55;
      for (int s = 0; s < 3; s++) begin
        lu_valid = 1'b1; lu_reg = (s == 0) ? 5'd1 : (s == 1) ? 5'd2 : 5'd4;
        lu_data = $urandom;
        for (int k = 0; k < 12; k++) begin
          step();
          hold++;
          if (hold >= 4) wb_en = 1'b0;
          if (last_acc) break;
        end
        chk("full_accept", 32'(last_acc), 32'd1);
      end
      lu_valid = 1'b0;
      step(); step();
    end

    // x0: pipeline write to x0 leaves the slot free
    issue(5'd7);
    wb_en = 1'b1; wb_reg = 5'd3;
    send(5'd7, 32'hAA);
    wb_reg = 5'd0;
    step();
    wb_en = 1'b0;
    send(5'd0, 32'hDEAD);
    chk_rs1 = 5'd0;
    issue(5'd0);
    step();

    // same-cycle set and clear, then stray result
    issue(5'd9);
    wb_en = 1'b1; wb_reg = 5'd3;
    send(5'd9, 32'h99);
    wb_en = 1'b0;
    issue(5'd9);
    chk_rs1 = 5'd9;
    step();
    send(5'd11, 32'hBAD);
    step(); step();

    // reset with two buffered results and x8 pending
    issue(5'd8); issue(5'd12); issue(5'd13);
    wb_en = 1'b1; wb_reg = 5'd3;
    send(5'd12, 32'hC);
    send(5'd13, 32'hD);
    chk_rs1 = 5'd8;
    rstn = 1'b0;
    step();
    rstn = 1'b1; wb_en = 1'b0;
    step(); step();

    // randomized traffic
    outq.delete();
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] r;
      rstn    = ($urandom % 400) != 0;
      wb_en   = $urandom % 2;
      wb_reg  = $urandom % 32;
      wb_data = $urandom;
      chk_rs1 = $urandom % 32; chk_rs2 = $urandom % 32; chk_rd = $urandom % 32;
      issue_en = 1'b0;
      r = $urandom % 32;
      if (($urandom % 3) == 0 && !pend[r]) begin
        issue_en = 1'b1; issue_reg = r;
      end
      if (!lu_valid && ($urandom % 2) == 1) begin
        if (outq.size() != 0) begin
          lu_valid = 1'b1; lu_reg = outq.pop_front(); lu_data = $urandom;
        end else if (($urandom % 8) == 0) begin
          lu_valid = 1'b1; lu_reg = 5'd0; lu_data = $urandom;
        end
      end
      if (!rstn) lu_valid = 1'b0;
      step();
      if (!rstn) begin
        outq.delete();
      end else begin
        if (last_acc) lu_valid = 1'b0;
        if (issue_en && issue_reg != 5'd0) outq.push_back(issue_reg);
      end
    end
    rstn = 1'b1; issue_en = 1'b0; lu_valid = 1'b0; wb_en = 1'b0;
    step(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
